dmem_lsu_port: RTL and testbench
================================

Name: dmem_lsu_port

Overview:
- Load/store initiator that drives the data port (port B) of the core's byte-write true-dual-port BRAM.
- Accepts one RV32 load/store request at a time from the execute/memory stage.
- For stores, generates byte enables and lane-aligned write data.
- For loads, issues the read, waits out the BRAM's one-cycle registered read latency, and returns the sign- or zero-extended result with a valid/ready response handshake.

Parameters:
- ADDR_WIDTH, 15, word-address width of the BRAM; depth is 2**ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to BRAM word 0; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request transfers when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (rs2).
- resp_valid  out  1  response present; held until resp_ready.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- mem_en  out  1  BRAM port-B enable (registered).
- mem_we  out  4  BRAM port-B byte write enables (registered).
- mem_addr  out  ADDR_WIDTH  BRAM word address (registered).
- mem_wdata  out  32  lane-aligned write data (registered).
- mem_rdata  in  32  BRAM port-B read data; valid the cycle after the BRAM samples mem_en.

Behaviour:
- Reset (async, any state): state = IDLE. mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. resp_valid = 0, resp_rdata = 0, resp_err = 0. Any in-flight transaction is discarded with no response; a BRAM write already sampled is not undone.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE, on accept:
  - Compute off = req_addr - BASE_ADDR.
  - Error if any of: off[31:ADDR_WIDTH+2] != 0; halfword access with off[0] = 1; word access with off[1:0] != 0; illegal funct3 (load 011/110/111, store 011-111).
  - On error: go to RESP with resp_err = 1, resp_rdata = 0. No BRAM access; mem_en and mem_we stay 0.
  - Otherwise: mem_en = 1, mem_addr = off[ADDR_WIDTH+1:2], go to ACCESS.
  - Store byte enables: SB = 4'b0001 << off[1:0]; SH = 4'b0011 << off[1:0]; SW = 4'b1111.
  - Store data: mem_wdata = byte/half replicated across all lanes (SB {4{b}}, SH {2{h}}, SW = wdata). Load: mem_we = 0.
  - Store the latched funct3 and off[1:0] for later extraction.
- ACCESS (1 cycle): BRAM samples at the closing edge. At that edge, mem_en and mem_we return to 0, and state goes to CAPTURE.
- CAPTURE (1 cycle):
  - Loads: select the lane from mem_rdata by the latched off[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU) into resp_rdata.
  - Stores: resp_rdata = 0.
  - resp_err = 0, resp_valid = 1, go to RESP.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready. On handshake, resp_valid = 0 and return to IDLE; a new request is accepted no earlier than the following cycle.
- Latency, counted from the accept edge: valid access has resp_valid asserted 3 cycles later; error has it 1 cycle later.
- Throughput: with resp_ready tied high, one transaction per 4 cycles.
- Read-first BRAM: a store's response carries no data. A load after a store to the same word sees the new data, because the store has completed before the next accept.
- mem_en is asserted for exactly one cycle per valid request, never during errors or reset.

Decomposition:
- Shared package / header (rv_mem_defs):
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encodings.
  - XLEN = 32 and NUM_COL = 4.
- One natural sub-module: dmem_load_align, a combinational block taking (mem_rdata, off[1:0], funct3) and producing the extended rdata, instantiated in CAPTURE. Store lane/byte-enable generation stays inline.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we = 4'b1111 and mem_addr = 4 for one cycle; the LW response is resp_rdata = 0xDEADBEEF, resp_err = 0, 3 cycles after accept.
- Word 4 = 0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
- SB addr 0x11 data 0x000000AA onto word 0x11223344, then LW 0x10 -> mem_we = 4'b0010, mem_wdata = 0xAAAAAAAA; the read returns 0x1122AA44.
- LW 0x12, SH 0x03, funct3 3'b011, and addr 0x0002_0000 (ADDR_WIDTH = 15) -> resp_err = 1, resp_rdata = 0, resp_valid 1 cycle after accept, mem_en never asserted.
- resp_ready held low 5 cycles after an LW -> resp_valid and resp_rdata stable throughout, req_ready = 0; returns to IDLE the cycle after resp_ready rises.
- reset asserted during ACCESS of an SW, then an LW -> all outputs 0 immediately and no response issued; after release, req_ready = 1 and the next LW completes normally.

Source files
------------

// File: rtl/rv_mem_defs.sv
// Shared definitions for the data-memory load/store port: RV32 funct3 codes,
// datapath widths and the LSU FSM state encoding.
package rv_mem_defs;

  localparam int XLEN    = 32;
  localparam int NUM_COL = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword lane of a BRAM read word and
// sign- or zero-extends it according to the load funct3.
module dmem_load_align
  import rv_mem_defs::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_port.sv
// Single-outstanding RV32 load/store initiator driving port B of a byte-write
// BRAM with one-cycle registered read latency.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge.
module dmem_lsu_port
  import rv_mem_defs::*;
#(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            dbg_state
);

  lsu_state_e            state_q, state_d;
  logic                  mem_en_q, mem_en_d;
  logic [NUM_COL-1:0]    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d;
  logic                  store_q, store_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [31:0]        off;
  logic               req_err;
  logic               f3_ok;
  logic [NUM_COL-1:0] st_be;
  logic [31:0]        st_data;
  logic [31:0]        ld_data;

  dmem_load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (lane_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  // Request decode: range, alignment and funct3 legality plus store lanes.
  always_comb begin
    off   = req_addr - BASE_ADDR;
    f3_ok = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                   : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    req_err = ((off >> (ADDR_WIDTH + 2)) != 32'h0) || !f3_ok
           || ((req_funct3[1:0] == 2'b01) && off[0])
           || ((req_funct3[1:0] == 2'b10) && (off[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << off[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << off[1:0];
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    store_d      = store_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          lane_d  = off[1:0];
          store_d = req_we;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = ST_RESP;
          end else begin
            mem_en_d    = 1'b1;
            mem_we_d    = req_we ? st_be : 4'b0000;
            mem_addr_d  = off[ADDR_WIDTH+1:2];
            mem_wdata_d = req_we ? st_data : 32'h0;
            state_d     = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 4'b0000;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        resp_rdata_d = store_q ? 32'h0 : ld_data;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f3_q         <= '0;
      lane_q       <= '0;
      store_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      store_q      <= store_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_lsu_port.sv
// Directed plus randomised bench for dmem_lsu_port with a behavioural
// read-first byte-write BRAM on port B and an expected-response queue.
module tb_dmem_lsu_port;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [1:0]    dbg_state;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [32:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          en_cnt = 0;
  logic [3:0]    last_we;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;

  dmem_lsu_port #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Read-first byte-write BRAM model
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++;
      last_we    = mem_we;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  by;
    logic [15:0] hw;
    by = (a == 2'd0) ? w[7:0] : (a == 2'd1) ? w[15:8] : (a == 2'd2) ? w[23:16] : w[31:24];
    hw = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return by[7] ? {24'hFFFFFF, by} : {24'h0, by};
      3'b001:  return hw[15] ? {16'hFFFF, hw} : {16'h0, hw};
      3'b100:  return {24'h0, by};
      3'b101:  return {16'h0, hw};
      default: return w;
    endcase
  endfunction

  // Driver: waits for req_ready, transfers one request, checks latency and
  // the number of BRAM enable pulses, and leaves the response pending.
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
    int n;
    int en0;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "/req_ready"}, {32'h0, req_ready}, 33'd1);
    exp_q.push_back({exp_err, exp_rd});
    en0 = en_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "/latency"}, 33'(n), exp_err ? 33'd1 : 33'd3);
    chk({tag, "/en_pulses"}, 33'(en_cnt - en0), exp_err ? 33'd0 : 33'd1);
  endtask

  // Scoreboard pop at the response handshake, then confirm return to IDLE.
  task automatic finish_resp(input string tag);
    logic [32:0] e;
    resp_ready = 1'b1;
    chk({tag, "/resp_valid"}, {32'h0, resp_valid}, 33'd1);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL %s/scoreboard: observed response expected none", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/resp"}, {resp_err, resp_rdata}, e);
    end
    @(posedge clk); #1;
    chk({tag, "/idle_after"}, {31'h0, resp_valid, req_ready}, 33'b01);
  endtask

  task automatic store_load(input string tag, input logic [2:0] sf3, input logic [31:0] saddr,
                            input logic [31:0] sdata, input logic [2:0] lf3,
                            input logic [31:0] laddr, input logic [31:0] exp_rd);
    issue({tag, "/st"}, 1'b1, sf3, saddr, sdata, 1'b0, 32'h0);
    finish_resp({tag, "/st"});
    issue({tag, "/ld"}, 1'b0, lf3, laddr, 32'h0, 1'b0, exp_rd);
    finish_resp({tag, "/ld"});
  endtask

  initial begin
    logic [31:0] hold_rd;
    int          idx;
    logic [31:0] d;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [2:0]  f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    repeat (3) @(posedge clk);
    #1;
    chk("reset/outs", {resp_valid, resp_err, mem_en, mem_we, 27'(mem_addr)}, 33'h0);
    chk("reset/data", {1'b0, resp_rdata | mem_wdata}, 33'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset/state", {31'h0, dbg_state}, 33'd0);

    // SW then LW at 0x10
    issue("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("sw10/we", {29'h0, last_we}, 33'hF);
    chk("sw10/addr", 33'(last_addr), 33'd4);
    chk("sw10/wdata", {1'b0, last_wdata}, {1'b0, 32'hDEADBEEF});
    finish_resp("sw10");
    issue("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    finish_resp("lw10");

    // Sub-word loads from 0x80FF7F01
    issue("sw_pat", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 1'b0, 32'h0);
    finish_resp("sw_pat");
    issue("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80); finish_resp("lb13");
    issue("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080); finish_resp("lbu13");
    issue("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF); finish_resp("lh12");
    issue("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h00007F01); finish_resp("lhu10");

    // Byte / halfword stores into 0x11223344
    issue("sw_base", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0);
    finish_resp("sw_base");
    issue("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 1'b0, 32'h0);
    chk("sb11/we", {29'h0, last_we}, 33'b0010);
    chk("sb11/wdata", {1'b0, last_wdata}, {1'b0, 32'hAAAAAAAA});
    finish_resp("sb11");
    issue("lw_sb", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1122AA44); finish_resp("lw_sb");
    issue("sh12", 1'b1, 3'b001, 32'h12, 32'h1234BEEF, 1'b0, 32'h0);
    chk("sh12/we", {29'h0, last_we}, 33'b1100);
    chk("sh12/wdata", {1'b0, last_wdata}, {1'b0, 32'hBEEFBEEF});
    finish_resp("sh12");
    issue("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44); finish_resp("lw_sh");

    // Error cases: misaligned, illegal funct3, out of range
    issue("e_lw12", 1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0); finish_resp("e_lw12");
    issue("e_sh03", 1'b1, 3'b001, 32'h03, 32'h5555, 1'b1, 32'h0); finish_resp("e_sh03");
    issue("e_ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0); finish_resp("e_ld011");
    issue("e_st100", 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0); finish_resp("e_st100");
    issue("e_range", 1'b0, 3'b010, 32'h0002_0000, 32'h0, 1'b1, 32'h0); finish_resp("e_range");
    issue("e_lh_odd", 1'b0, 3'b101, 32'h11, 32'h0, 1'b1, 32'h0); finish_resp("e_lh_odd");

    // Highest in-range word
    store_load("top", 3'b010, 32'h0001_FFFC, 32'hA5C3_0F96, 3'b000, 32'h0001_FFFF, 32'hFFFFFFA5);

    // Back-pressure: resp_ready low for 5 cycles
    resp_ready = 1'b0;
    issue("hold", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44);
    hold_rd = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold/stable", {resp_valid, resp_rdata}, {1'b1, hold_rd});
      chk("hold/busy", {30'h0, req_ready, dbg_state}, 33'b011);
    end
    finish_resp("hold");

    // Randomised store/load pairs
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(64, 127);
      d   = $urandom;
      f3  = f3_tab[$urandom_range(0, 4)];
      a   = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
            (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      store_load("rnd", 3'b010, 32'(idx * 4), d, f3, 32'(idx * 4) + 32'(a), ld_model(d, a, f3));
    end

    // Reset during ACCESS of a store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst/in_access", {31'h0, dbg_state}, 33'd1);
    reset = 1'b1;
    #1;
    chk("rst/outs", {resp_valid, resp_err, mem_en, mem_we, 27'(mem_addr)}, 33'h0);
    chk("rst/data", {1'b0, resp_rdata | mem_wdata}, 33'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst/no_resp", {31'h0, resp_valid, req_ready}, 33'b01);
    end
    issue("post_rst", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44);
    finish_resp("post_rst");

    chk("sb/empty", 33'(exp_q.size()), 33'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
